// File: rtl/hex_seg_pkg.sv
// Shared seven-segment definitions: glyph constants, segment type, nibble width.
// Latency: n/a (package only).
// Backpressure: n/a. Also used by the display driver, so glyph encodings must stay in sync.
package hex_seg_pkg;

  // Active-low segment pattern, bit0 = seg a ... bit6 = seg g.
  typedef logic [6:0] seg_t;

  localparam int NIBBLE_W = 4;

  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

  // Output-side state of the scan reader.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/seg_to_nibble.sv
// Decodes one active-low seven-segment glyph back to its hex nibble.
// Latency: combinational.
// Backpressure: none. Ports: seg (glyph in), nibble (value, 0 when illegal), err (not a hex glyph).
module seg_to_nibble
  import hex_seg_pkg::*;
(
  input  logic [6:0]          seg,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                err
);

  always_comb begin
    nibble = '0;
    err    = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_scan_reader.sv
// Watches a multiplexed active-low 7-seg bus and rebuilds the displayed hex word.
// Latency: o_valid rises STABLE_CYCLES edges after the last digit's first stable sample.
// Backpressure: o_valid/i_ready; a frame completing while o_valid & ~i_ready is dropped and o_overrun latches.
// Ports: clk, reset (sync, active-high); i_seg/i_dig_sel scan bus in; o_value/o_err_mask/o_valid/i_ready
// frame out; o_overrun sticky drop flag. Optional macro HEX_SCAN_DP_EN adds i_dp (active-low point) and
// o_dp_mask (lit points per digit).
module hex_scan_reader
  import hex_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [6:0]                     i_seg,
  input  logic [NUM_DIGITS-1:0]          i_dig_sel,
  output logic [NIBBLE_W*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]          o_err_mask,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_overrun
`ifdef HEX_SCAN_DP_EN
  ,
  input  logic                           i_dp,
  output logic [NUM_DIGITS-1:0]          o_dp_mask
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

`ifdef HEX_SCAN_DP_EN
  localparam int SAMPLE_W = 7 + NUM_DIGITS + 1;
  logic [SAMPLE_W-1:0] sample;
  assign sample = {i_dp, i_seg, i_dig_sel};
`else
  localparam int SAMPLE_W = 7 + NUM_DIGITS;
  logic [SAMPLE_W-1:0] sample;
  assign sample = {i_seg, i_dig_sel};
`endif

  logic [SAMPLE_W-1:0]              prev_sample;
  logic [CNT_W-1:0]                 stable_cnt, stable_cnt_nxt;
  logic                             sel_onehot, same_sample, capture;
  logic [NIBBLE_W-1:0]              dec_nibble;
  logic                             dec_err;
  logic [NIBBLE_W*NUM_DIGITS-1:0]   slot_value, slot_value_nxt;
  logic [NUM_DIGITS-1:0]            slot_err, slot_err_nxt;
  logic [NUM_DIGITS-1:0]            captured;
  logic                             frame_done, transfer, load, drop;
  out_state_e                       state, state_nxt;

  seg_to_nibble u_dec (
    .seg    (i_seg),
    .nibble (dec_nibble),
    .err    (dec_err)
  );

  assign sel_onehot  = $onehot(i_dig_sel);
  assign same_sample = (sample == prev_sample);

  // Capture fires only on the step into saturation, so a long dwell samples once.
  assign capture = sel_onehot && same_sample && (stable_cnt == CNT_MAX - CNT_W'(1));

  always_comb begin
    stable_cnt_nxt = '0;
    if (sel_onehot) begin
      if (!same_sample)
        stable_cnt_nxt = CNT_W'(1);
      else if (stable_cnt == CNT_MAX)
        stable_cnt_nxt = CNT_MAX;
      else
        stable_cnt_nxt = stable_cnt + CNT_W'(1);
    end
  end

  // Slot contents including this cycle's capture, so a completing frame
  // can be loaded on the same edge as its last digit.
  always_comb begin
    slot_value_nxt = slot_value;
    slot_err_nxt   = slot_err;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (capture && i_dig_sel[k]) begin
        slot_value_nxt[k*NIBBLE_W +: NIBBLE_W] = dec_nibble;
        slot_err_nxt[k]                        = dec_err;
      end
    end
  end

  assign frame_done = capture && (&(captured | i_dig_sel));
  assign transfer   = o_valid && i_ready;
  assign load       = frame_done && (!o_valid || i_ready);
  assign drop       = frame_done && o_valid && !i_ready;
  assign o_valid    = (state == ST_FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (frame_done)           state_nxt = ST_FULL;
      ST_FULL:  if (transfer && !load)    state_nxt = ST_EMPTY;
      default:                            state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_EMPTY;
      prev_sample <= '0;
      stable_cnt  <= '0;
      slot_value  <= '0;
      slot_err    <= '0;
      captured    <= '0;
      o_value     <= '0;
      o_err_mask  <= '0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_sample <= sample;
      stable_cnt  <= stable_cnt_nxt;
      slot_value  <= slot_value_nxt;
      slot_err    <= slot_err_nxt;
      if (frame_done)
        captured <= '0;
      else if (capture)
        captured <= captured | i_dig_sel;
      if (load) begin
        o_value    <= slot_value_nxt;
        o_err_mask <= slot_err_nxt;
      end
      // A drop can only happen without a transfer, so the two never collide.
      if (transfer)
        o_overrun <= 1'b0;
      else if (drop)
        o_overrun <= 1'b1;
    end
  end

`ifdef HEX_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] slot_dp, slot_dp_nxt;

  always_comb begin
    slot_dp_nxt = slot_dp;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (capture && i_dig_sel[k])
        slot_dp_nxt[k] = !i_dp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_dp   <= '0;
      o_dp_mask <= '0;
    end else begin
      slot_dp <= slot_dp_nxt;
      if (load)
        o_dp_mask <= slot_dp_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_hex_scan_reader.sv
module tb_hex_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [6:0]        i_seg;
  logic [ND-1:0]     i_dig_sel;
  logic [4*ND-1:0]   o_value;
  logic [ND-1:0]     o_err_mask;
  logic              o_valid;
  logic              i_ready;
  logic              o_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_seg      (i_seg),
    .i_dig_sel  (i_dig_sel),
    .o_value    (o_value),
    .o_err_mask (o_err_mask),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overrun  (o_overrun)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {err, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (glyph[i] == s) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  // ---------------- behavioural reference model ----------------
  int            run_len;
  logic [6:0]    p_seg;
  logic [ND-1:0] p_sel;
  logic [3:0]    s_nib [ND];
  logic          s_err [ND];
  logic [ND-1:0] cap_mask;
  logic          m_valid, m_overrun;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0] m_err;
  logic          started = 1'b0;

  always @(posedge clk) begin
    logic xfer;
    logic [4:0] d;
    started = 1'b1;
    if (reset) begin
      run_len = 0; p_seg = '0; p_sel = '0; cap_mask = '0;
      m_valid = 0; m_overrun = 0; m_value = '0; m_err = '0;
    end else begin
      xfer = m_valid && i_ready;
      if (xfer) begin
        m_valid   = 0;
        m_overrun = 0;
      end
      if ($countones(i_dig_sel) == 1) begin
        if (i_seg == p_seg && i_dig_sel == p_sel) run_len++;
        else run_len = 1;
        if (run_len == SC) begin
          d = decode(i_seg);
          for (int k = 0; k < ND; k++)
            if (i_dig_sel[k]) begin
              s_nib[k] = d[3:0];
              s_err[k] = d[4];
              cap_mask[k] = 1'b1;
            end
          if (&cap_mask) begin
            if (!m_valid) begin
              m_valid = 1;
              for (int k = 0; k < ND; k++) begin
                m_value[4*k +: 4] = s_nib[k];
                m_err[k] = s_err[k];
              end
            end else begin
              m_overrun = 1;
            end
            cap_mask = '0;
          end
        end
      end else begin
        run_len = 0;
      end
      p_seg = i_seg;
      p_sel = i_dig_sel;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(o_valid), 32'(m_valid));
      chk("overrun", 32'(o_overrun), 32'(m_overrun));
      if (m_valid) begin
        chk("value", 32'(o_value), 32'(m_value));
        chk("err_mask", 32'(o_err_mask), 32'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input logic r);
    i_seg = s; i_dig_sel = d; i_ready = r;
    @(negedge clk);
  endtask

  task automatic dwell(input int k, input logic [6:0] s, input int n, input logic r);
    for (int c = 0; c < n; c++) step(s, ND'(1) << k, r);
  endtask

  // segs packed as {d3, d2, d1, d0}
  task automatic scan(input logic [27:0] segs, input int n, input logic r);
    for (int k = 0; k < ND; k++) dwell(k, segs[7*k +: 7], n, r);
  endtask

  initial begin
    reset = 1'b1; i_seg = 7'h7F; i_dig_sel = '0; i_ready = 1'b0;
    @(negedge clk);
    step(7'h7F, '0, 1'b0);
    step(7'h7F, '0, 1'b0);
    reset = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_value", 32'(o_value), 32'd0);
    chk("rst_err", 32'(o_err_mask), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);

    // Basic frame, consumer ready.
    scan({7'h46, 7'h08, 7'h00, 7'h30}, 4, 1'b1);
    chk("f1_valid", 32'(o_valid), 32'd1);
    chk("f1_value", 32'(o_value), 32'h0000CA83);
    chk("f1_err", 32'(o_err_mask), 32'd0);
    step(7'h7F, '0, 1'b1);
    chk("f1_valid_drop", 32'(o_valid), 32'd0);

    // Hold, then overrun.
    scan({7'h46, 7'h08, 7'h00, 7'h30}, 4, 1'b0);
    chk("hold_valid", 32'(o_valid), 32'd1);
    scan({7'h12, 7'h19, 7'h79, 7'h40}, 4, 1'b0);
    chk("ovr_flag", 32'(o_overrun), 32'd1);
    chk("ovr_value", 32'(o_value), 32'h0000CA83);
    step(7'h7F, '0, 1'b1);
    chk("ovr_xfer_valid", 32'(o_valid), 32'd0);
    chk("ovr_clear", 32'(o_overrun), 32'd0);

    // Illegal glyph on digit 2.
    scan({7'h46, 7'h7F, 7'h00, 7'h30}, 4, 1'b1);
    chk("blank_value", 32'(o_value), 32'h0000C083);
    chk("blank_err", 32'(o_err_mask), 32'h4);
    step(7'h7F, '0, 1'b1);

    // Too-short dwells and a multi-hot strobe never capture.
    scan({7'h46, 7'h08, 7'h00, 7'h30}, 3, 1'b1);
    scan({7'h46, 7'h08, 7'h00, 7'h30}, 3, 1'b1);
    for (int c = 0; c < 10; c++) step(7'h30, 4'b0110, 1'b1);
    chk("noshort_valid", 32'(o_valid), 32'd0);

    // Recapture: digit 1 shows 1, then 7 before completion.
    dwell(1, 7'h79, 4, 1'b1);
    dwell(0, 7'h30, 4, 1'b1);
    dwell(1, 7'h78, 4, 1'b1);
    dwell(2, 7'h08, 4, 1'b1);
    dwell(3, 7'h46, 4, 1'b1);
    chk("recap_valid", 32'(o_valid), 32'd1);
    chk("recap_nib1", 32'(o_value[7:4]), 32'h7);
    chk("recap_value", 32'(o_value), 32'h0000CA73);
    step(7'h7F, '0, 1'b1);

    // Reset after a partial frame drops those captures.
    dwell(0, 7'h40, 4, 1'b1);
    dwell(1, 7'h79, 4, 1'b1);
    reset = 1'b1;
    step(7'h7F, '0, 1'b1);
    reset = 1'b0;
    dwell(2, 7'h06, 4, 1'b1);
    dwell(3, 7'h0E, 4, 1'b1);
    chk("rstmid_nostale", 32'(o_valid), 32'd0);
    dwell(0, 7'h03, 4, 1'b1);
    dwell(1, 7'h21, 4, 1'b1);
    chk("rstmid_valid", 32'(o_valid), 32'd1);
    chk("rstmid_value", 32'(o_value), 32'h0000FEDB);
    step(7'h7F, '0, 1'b1);

    // Randomized dwells against the model.
    for (int n = 0; n < 600; n++) begin
      logic [6:0]    s;
      logic [ND-1:0] d;
      int            len;
      if ($urandom_range(99) < 85) s = glyph[$urandom_range(15)];
      else                          s = 7'($urandom);
      if ($urandom_range(99) < 85) d = ND'(1) << $urandom_range(ND-1);
      else                          d = ND'($urandom);
      len = $urandom_range(6, 1);
      reset = ($urandom_range(199) == 0);
      for (int c = 0; c < len; c++) begin
        step(s, d, 1'($urandom_range(99) < 40));
        reset = 1'b0;
      end
    end

    step(7'h7F, '0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_reader.md
Name: hex_scan_reader

Overview:
- Reader side of the seven-segment display path. It watches a time-multiplexed, active-low 7-segment bus (segment pattern plus one-hot digit strobe) and turns each stable digit pattern back into its hex nibble.
- Assembles NUM_DIGITS nibbles into one word and presents it on a valid/ready output.
- Used for display loop-back checking and for capturing scanned displays from external boards.

Parameters:
- NUM_DIGITS, 4, number of digit positions per frame (1..8).
- STABLE_CYCLES, 4, consecutive identical cycles needed before a digit is sampled (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_seg  in  7  active-low segment pattern; bit0 = seg a ... bit6 = seg g; 1 = segment off
- i_dig_sel  in  NUM_DIGITS  one-hot digit strobe; bit k = digit k (digit 0 = least-significant nibble)
- o_value  out  4*NUM_DIGITS  assembled word; digit k sits in bits [4k+3:4k]
- o_err_mask  out  NUM_DIGITS  bit k set = digit k pattern was not a legal hex glyph
- o_valid  out  1  frame available
- i_ready  in  1  consumer accepts the frame
- o_overrun  out  1  sticky: a completed frame was dropped while o_valid was high

Behaviour:
- Reset (synchronous, active-high): o_value=0, o_err_mask=0, o_valid=0, o_overrun=0. Stability counter, last-sample registers and captured mask all clear. Reset asserted mid-frame discards partial captures.
- Glyph table (i_seg as 7'h, bits g..a), digit 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Any other pattern (e.g. 7F blank) is illegal: nibble = 0, err = 1.
- Stability tracking, every cycle:
  - If i_dig_sel is not exactly one-hot (zero or multi-hot): clear the counter; nothing is captured.
  - Else, if {i_seg, i_dig_sel} equals the previous cycle's value: increment the counter, saturating at STABLE_CYCLES.
  - Else: set the counter to 1.
- Capture: at the edge where the counter becomes STABLE_CYCLES-1 -> STABLE_CYCLES (the STABLE_CYCLES-th consecutive identical sample):
  - write the decoded nibble and err bit into frame slot k;
  - set captured[k].
  - Exactly one capture per dwell; a saturated counter does not recapture.
- Recapture of an already captured digit in the same frame overwrites it (latest wins).
- Frame completion: when a capture makes the captured mask all-ones, at that same edge:
  - if o_valid=0, or o_valid=1 with i_ready=1 this cycle: load o_value/o_err_mask from the frame slots (including the new capture); o_valid=1.
  - otherwise: drop the frame and set o_overrun=1.
  - In both cases the captured mask clears. Latency from first stable sample of the last digit to o_valid = STABLE_CYCLES edges.
- Output handshake:
  - Transfer occurs on any edge with o_valid & i_ready. o_valid then drops, unless a frame completes on the same edge, in which case it stays high with new data.
  - o_value and o_err_mask are stable while o_valid=1 and i_ready=0.
  - o_overrun clears only on a completed transfer, or on reset.
- FSM (output side):
  - EMPTY -> FULL on frame completion.
  - FULL -> EMPTY on transfer without a simultaneous completion.
  - FULL -> FULL on transfer with completion.
  - Capture logic runs in both states.

Optional Feature:
- Macro: HEX_SCAN_DP_EN.
- Defined: adds input i_dp (1, active-low decimal point) and output o_dp_mask (NUM_DIGITS).
  - i_dp is part of the stability comparison and is captured per digit alongside the nibble.
  - o_dp_mask bit k = 1 when the point was lit; it follows the same load/hold rules as o_value. Reset value 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package hex_seg_pkg:
  - typedef seg_t (logic [6:0]);
  - 16 glyph constants SEG_0..SEG_F;
  - NIBBLE_W = 4.
  - The package is shared with the display driver.
- One sub-module, seg_to_nibble: combinational seg_t -> {nibble, err}, implementing the glyph table. Instantiated once.

Test Plan:
- Reset, then scan digits 0..3 with patterns 30,00,08,46 (values 3,8,A,C), 4 cycles each, i_ready=1 -> o_valid one cycle, o_value=16'hCA83, o_err_mask=0.
- Same scan with i_ready=0 -> o_valid held, value stable. A second full frame arrives -> o_overrun=1 and value unchanged. Raise i_ready -> transfer, o_overrun=0.
- Digit 2 shows 7F (blank), others legal -> o_err_mask=4'b0100, nibble 2 = 0.
- Digit held only 3 cycles (STABLE_CYCLES=4), or i_dig_sel=4'b0110 for 10 cycles -> no capture, o_valid stays 0.
- Digit 1 captured as 1 (79), then recaptured as 7 (78) before the frame completes -> o_value[7:4]=4'h7.
- Reset asserted after 2 of 4 digits are captured -> next full scan yields only the new frame's values; no stale nibbles.
